// File: rtl/lcd_bus_snoop_pkg.sv
// Constants and helpers shared by the LCD bus snooper and the LCD driver:
// controller opcodes, panel geometry and the column-advance rule.
package lcd_bus_snoop_pkg;

  localparam int X_PER_MODULE_C   = 50;
  localparam int MAX_X_C          = 240;
  localparam int MODULE_ROW_SPLIT = 5;

  localparam logic [7:0] OP_DISPLAY_ON  = 8'h39;
  localparam logic [7:0] OP_DISPLAY_OFF = 8'h38;
  localparam logic [7:0] OP_MODE_UP     = 8'h3B;
  localparam logic [7:0] OP_MODE_DOWN   = 8'h3A;
  localparam logic [5:0] OP_START_PAGE  = 6'b111110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } snoop_state_e;

  // Column after a data write: wraps at both ends of the module's width.
  function automatic logic [5:0] next_column(input logic [5:0] col,
                                             input logic       up,
                                             input logic [5:0] last);
    logic [5:0] nxt;
    if (up) begin
      nxt = (col == last) ? 6'd0 : col + 6'd1;
    end else begin
      nxt = (col == 6'd0) ? last : col - 6'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_module_state.sv
// Per-controller register bank: column, page, up/down mode and display-on,
// updated by decoded instructions and by post-write column advances.
module lcd_module_state
  import lcd_bus_snoop_pkg::*;
#(
  parameter int LCD_MODULES  = 10,
  parameter int X_PER_MODULE = X_PER_MODULE_C,
  parameter int IDX_W        = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        instr_valid,
  input  logic [LCD_MODULES-1:0]      instr_sel,
  input  logic [7:0]                  instr_data,
  input  logic                        adv_valid,
  input  logic [IDX_W-1:0]            adv_idx,
  output logic [LCD_MODULES-1:0][5:0] column,
  output logic [LCD_MODULES-1:0][1:0] page,
  output logic [LCD_MODULES-1:0]      display_on
);

  localparam logic [5:0] LAST_COL = 6'(X_PER_MODULE - 1);

  logic [LCD_MODULES-1:0][5:0] column_r;
  logic [LCD_MODULES-1:0][1:0] page_r;
  logic [LCD_MODULES-1:0]      display_on_r;
  logic [LCD_MODULES-1:0]      up_r;

  // Module state: instruction decode for selected modules, column advance after each write.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      column_r     <= '0;
      page_r       <= '0;
      display_on_r <= '0;
      up_r         <= '1;
    end else begin
      for (int i = 0; i < LCD_MODULES; i++) begin
        if (instr_valid && instr_sel[i]) begin
          case (instr_data)
            OP_DISPLAY_ON:  display_on_r[i] <= 1'b1;
            OP_DISPLAY_OFF: display_on_r[i] <= 1'b0;
            OP_MODE_UP:     up_r[i]         <= 1'b1;
            OP_MODE_DOWN:   up_r[i]         <= 1'b0;
            default: begin
              // Start-page is accepted but has no framebuffer effect.
              if ((instr_data[5:0] != OP_START_PAGE) &&
                  (instr_data[5:0] < 6'(X_PER_MODULE))) begin
                page_r[i]   <= instr_data[7:6];
                column_r[i] <= instr_data[5:0];
              end
            end
          endcase
        end else if (adv_valid && (adv_idx == IDX_W'(i))) begin
          column_r[i] <= next_column(column_r[i], up_r[i], LAST_COL);
        end
      end
    end
  end

  assign column     = column_r;
  assign page       = page_r;
  assign display_on = display_on_r;

endmodule

// File: rtl/lcd_bus_snoop.sv
// Passive snooper of a multi-controller LCD bus: tracks each controller's
// address state and turns display-data cycles into framebuffer writes.
module lcd_bus_snoop
  import lcd_bus_snoop_pkg::*;
#(
  parameter int LCD_MODULES  = 10,
  parameter int X_PER_MODULE = X_PER_MODULE_C,
  parameter int MAX_X        = MAX_X_C
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             data_pin,
  input  logic [LCD_MODULES-1:0] cs_pin,
  input  logic                   cs1_pin,
  input  logic                   rw_pin,
  input  logic                   di_pin,
  input  logic                   enable_pin,
  input  logic                   reset_pin,
  output logic [7:0]             fb_x,
  output logic [2:0]             fb_y,
  output logic [7:0]             fb_data,
  output logic                   fb_write,
  output logic [LCD_MODULES-1:0] display_on,
  output logic                   overrun
);

  localparam int IDX_W  = (LCD_MODULES > 1) ? $clog2(LCD_MODULES) : 1;
  localparam int SYNC_W = LCD_MODULES + 13;
  // Enable and reset_pin idle high so reset never fakes a falling edge.
  localparam logic [SYNC_W-1:0] SYNC_INIT = {1'b1, 3'b000, {LCD_MODULES{1'b0}}, 8'h00, 1'b1};

  logic [SYNC_W-1:0]           bus_raw_s, sync1_r, sync2_r;
  logic                        en_s, cs1_s, rw_s, di_s, lcd_rst_n_s, lcd_clear_s;
  logic [7:0]                  data_s;
  logic [LCD_MODULES-1:0]      cs_s;
  logic                        en_prev_r, bus_fall_s;
  logic                        cap_valid_r, cap_di_r;
  logic [7:0]                  cap_data_r, scan_data_r;
  logic [LCD_MODULES-1:0]      cap_cs_r;
  snoop_state_e                state_r, state_next_s;
  logic [LCD_MODULES-1:0]      pend_r, pend_next_s, pick_s;
  logic [LCD_MODULES-1:0][5:0] col_s;
  logic [LCD_MODULES-1:0][1:0] page_s;
  logic [5:0]                  col_sel_s;
  logic [1:0]                  page_sel_s;
  logic                        row_sel_s;
  logic [9:0]                  base_sel_s, x_wide_s;
  logic [2:0]                  y_s;
  logic [IDX_W-1:0]            adv_idx_s;
  logic                        adv_valid_s, instr_valid_s, wr_s, overrun_set_s, scan_load_s;

  assign bus_raw_s   = {reset_pin, di_pin, rw_pin, cs1_pin, cs_pin, data_pin, enable_pin};
  assign en_s        = sync2_r[0];
  assign data_s      = sync2_r[8:1];
  assign cs_s        = sync2_r[LCD_MODULES+8:9];
  assign cs1_s       = sync2_r[LCD_MODULES+9];
  assign rw_s        = sync2_r[LCD_MODULES+10];
  assign di_s        = sync2_r[LCD_MODULES+11];
  assign lcd_rst_n_s = sync2_r[LCD_MODULES+12];
  assign lcd_clear_s = ~lcd_rst_n_s;
  assign bus_fall_s  = en_prev_r & ~en_s & cs1_s & ~rw_s & lcd_rst_n_s;

  // Shared 2-flop synchronizer, enable edge detect and bus-cycle capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r     <= SYNC_INIT;
      sync2_r     <= SYNC_INIT;
      en_prev_r   <= 1'b1;
      cap_valid_r <= 1'b0;
      cap_di_r    <= 1'b0;
      cap_data_r  <= 8'h00;
      cap_cs_r    <= '0;
    end else begin
      sync1_r     <= bus_raw_s;
      sync2_r     <= sync1_r;
      en_prev_r   <= en_s;
      cap_valid_r <= bus_fall_s;
      if (bus_fall_s) begin
        cap_di_r   <= di_s;
        cap_data_r <= data_s;
        cap_cs_r   <= cs_s;
      end
    end
  end

  lcd_module_state #(
    .LCD_MODULES (LCD_MODULES),
    .X_PER_MODULE(X_PER_MODULE),
    .IDX_W       (IDX_W)
  ) u_state (
    .clk        (clk),
    .reset      (reset),
    .clear      (lcd_clear_s),
    .instr_valid(instr_valid_s),
    .instr_sel  (cap_cs_r),
    .instr_data (cap_data_r),
    .adv_valid  (adv_valid_s),
    .adv_idx    (adv_idx_s),
    .column     (col_s),
    .page       (page_s),
    .display_on (display_on)
  );

  // Lowest pending module and its framebuffer coordinates (pick_s is one-hot or zero).
  always_comb begin
    pick_s     = pend_r & ((~pend_r) + LCD_MODULES'(1'b1));
    col_sel_s  = 6'd0;
    page_sel_s = 2'd0;
    row_sel_s  = 1'b0;
    base_sel_s = 10'd0;
    adv_idx_s  = {IDX_W{1'b0}};
    for (int i = 0; i < LCD_MODULES; i++) begin
      col_sel_s  = col_sel_s  | (pick_s[i] ? col_s[i]  : 6'd0);
      page_sel_s = page_sel_s | (pick_s[i] ? page_s[i] : 2'd0);
      row_sel_s  = row_sel_s  | (pick_s[i] && (i >= MODULE_ROW_SPLIT));
      base_sel_s = base_sel_s | (pick_s[i] ? 10'((i % MODULE_ROW_SPLIT) * X_PER_MODULE) : 10'd0);
      adv_idx_s  = adv_idx_s  | (pick_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
    x_wide_s = base_sel_s + 10'(col_sel_s);
    y_s      = {row_sel_s, page_sel_s};
  end

  // FSM next state: IDLE decodes captured cycles, SCAN serialises one module per clock.
  always_comb begin
    state_next_s  = state_r;
    pend_next_s   = pend_r;
    instr_valid_s = 1'b0;
    adv_valid_s   = 1'b0;
    wr_s          = 1'b0;
    overrun_set_s = 1'b0;
    scan_load_s   = 1'b0;
    if (!lcd_rst_n_s) begin
      state_next_s = ST_IDLE;
      pend_next_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cap_valid_r && !cap_di_r) begin
            instr_valid_s = 1'b1;
          end else if (cap_valid_r && (|cap_cs_r)) begin
            state_next_s = ST_SCAN;
            pend_next_s  = cap_cs_r;
            scan_load_s  = 1'b1;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_SCAN: begin
          overrun_set_s = cap_valid_r;
          adv_valid_s   = |pend_r;
          wr_s          = (|pend_r) && (x_wide_s < 10'(MAX_X));
          pend_next_s   = pend_r & ~pick_s;
          if (pend_next_s == '0) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_SCAN;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
          pend_next_s  = '0;
        end
      endcase
    end
  end

  // FSM state, pending-module mask and the byte being serialised.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      pend_r      <= '0;
      scan_data_r <= 8'h00;
    end else begin
      state_r <= state_next_s;
      pend_r  <= pend_next_s;
      if (scan_load_s) begin
        scan_data_r <= cap_data_r;
      end
    end
  end

  // Registered framebuffer port and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_write <= 1'b0;
      fb_x     <= 8'h00;
      fb_y     <= 3'd0;
      fb_data  <= 8'h00;
      overrun  <= 1'b0;
    end else begin
      fb_write <= wr_s;
      overrun  <= overrun | overrun_set_s;
      if (wr_s) begin
        fb_x    <= x_wide_s[7:0];
        fb_y    <= y_s;
        fb_data <= scan_data_r;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_snoop.sv
// Directed self-checking bench for lcd_bus_snoop: drives LCD bus cycles and
// compares logged framebuffer writes against hand-computed expectations.
module tb_lcd_bus_snoop;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_pin;
  logic [9:0] cs_pin;
  logic       cs1_pin, rw_pin, di_pin, enable_pin, reset_pin;
  logic [7:0] fb_x, fb_data;
  logic [2:0] fb_y;
  logic       fb_write, overrun;
  logic [9:0] display_on;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         wr_cyc_q[$];
  logic [7:0] wr_x_q[$];
  logic [2:0] wr_y_q[$];
  logic [7:0] wr_d_q[$];

  lcd_bus_snoop #(.LCD_MODULES(10), .X_PER_MODULE(50), .MAX_X(240)) dut (
    .clk(clk), .reset(reset), .data_pin(data_pin), .cs_pin(cs_pin),
    .cs1_pin(cs1_pin), .rw_pin(rw_pin), .di_pin(di_pin), .enable_pin(enable_pin),
    .reset_pin(reset_pin), .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data),
    .fb_write(fb_write), .display_on(display_on), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_write === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      wr_x_q.push_back(fb_x);
      wr_y_q.push_back(fb_y);
      wr_d_q.push_back(fb_data);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    wr_cyc_q.delete();
    wr_x_q.delete();
    wr_y_q.delete();
    wr_d_q.delete();
  endtask

  task automatic bus_cycle(input logic di, input logic [7:0] d, input logic [9:0] cs,
                           input logic c1, input logic rw, output int fall_cyc);
    @(negedge clk);
    data_pin = d; di_pin = di; cs_pin = cs; cs1_pin = c1; rw_pin = rw; enable_pin = 1'b1;
    repeat (2) @(negedge clk);
    enable_pin = 1'b0;
    fall_cyc = cyc;
    repeat (2) @(negedge clk);
    enable_pin = 1'b1;
  endtask

  task automatic instr(input logic [7:0] d, input logic [9:0] cs);
    int f;
    bus_cycle(1'b0, d, cs, 1'b1, 1'b0, f);
    settle(6);
  endtask

  task automatic data_wr(input logic [7:0] d, input logic [9:0] cs, output int f);
    bus_cycle(1'b1, d, cs, 1'b1, 1'b0, f);
    settle(16);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable_pin = 1'b1; cs1_pin = 1'b0; rw_pin = 1'b0; di_pin = 1'b0;
    data_pin = 8'h00; cs_pin = 10'h000; reset_pin = 1'b1;
    settle(4);
    checks++; if (fb_write !== 1'b0) begin errors++; $display("FAIL reset_fb_write got %0h want 0", fb_write); end
    checks++; if (fb_x !== 8'h00) begin errors++; $display("FAIL reset_fb_x got %0h want 0", fb_x); end
    checks++; if (fb_y !== 3'd0) begin errors++; $display("FAIL reset_fb_y got %0h want 0", fb_y); end
    checks++; if (fb_data !== 8'h00) begin errors++; $display("FAIL reset_fb_data got %0h want 0", fb_data); end
    checks++; if (display_on !== 10'h000) begin errors++; $display("FAIL reset_display_on got %0h want 0", display_on); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0h want 0", overrun); end
    clr();
    reset = 1'b0;
    settle(6);
    checks++; if (wr_x_q.size() != 0) begin errors++; $display("FAIL reset_no_spurious got %0d writes want 0", wr_x_q.size()); end
  endtask

  task automatic test_display();
    instr(8'h39, 10'h003);
    checks++; if (display_on !== 10'h003) begin errors++; $display("FAIL display_set got %0h want 003", display_on); end
    instr(8'h38, 10'h001);
    checks++; if (display_on !== 10'h002) begin errors++; $display("FAIL display_clr got %0h want 002", display_on); end
  endtask

  task automatic test_addr_write();
    int f;
    instr(8'h85, 10'h004);
    clr();
    data_wr(8'hAA, 10'h004, f);
    checks++;
    if (wr_x_q.size() != 1) begin
      errors++; $display("FAIL addr_count got %0d want 1", wr_x_q.size());
    end else begin
      checks++; if (wr_x_q[0] !== 8'd105) begin errors++; $display("FAIL addr_x got %0d want 105", wr_x_q[0]); end
      checks++; if (wr_y_q[0] !== 3'd2) begin errors++; $display("FAIL addr_y got %0d want 2", wr_y_q[0]); end
      checks++; if (wr_d_q[0] !== 8'hAA) begin errors++; $display("FAIL addr_data got %0h want aa", wr_d_q[0]); end
      checks++; if (wr_cyc_q[0] != f + 5) begin errors++; $display("FAIL latency got %0d want %0d", wr_cyc_q[0] - f, 5); end
    end
  endtask

  task automatic test_wrap();
    int f;
    logic [7:0] exp_dn[3];
    exp_dn = '{8'd1, 8'd0, 8'd49};
    instr(8'h31, 10'h001);
    clr();
    data_wr(8'h11, 10'h001, f);
    data_wr(8'h22, 10'h001, f);
    checks++;
    if (wr_x_q.size() != 2) begin
      errors++; $display("FAIL wrap_up_count got %0d want 2", wr_x_q.size());
    end else begin
      checks++; if (wr_x_q[0] !== 8'd49) begin errors++; $display("FAIL wrap_up_x0 got %0d want 49", wr_x_q[0]); end
      checks++; if (wr_x_q[1] !== 8'd0) begin errors++; $display("FAIL wrap_up_x1 got %0d want 0", wr_x_q[1]); end
      checks++; if (wr_d_q[1] !== 8'h22) begin errors++; $display("FAIL wrap_up_d1 got %0h want 22", wr_d_q[1]); end
    end
    instr(8'h3A, 10'h001);
    clr();
    for (int k = 0; k < 3; k++) data_wr(8'h33, 10'h001, f);
    checks++;
    if (wr_x_q.size() != 3) begin
      errors++; $display("FAIL wrap_dn_count got %0d want 3", wr_x_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (wr_x_q[k] !== exp_dn[k]) begin errors++; $display("FAIL wrap_dn_x%0d got %0d want %0d", k, wr_x_q[k], exp_dn[k]); end
      end
    end
    instr(8'h3B, 10'h001);
  endtask

  task automatic test_broadcast();
    int f;
    logic [7:0] exp_x[10];
    logic [2:0] exp_y[10];
    exp_x = '{8'd0, 8'd50, 8'd100, 8'd150, 8'd200, 8'd0, 8'd50, 8'd100, 8'd150, 8'd200};
    exp_y = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    instr(8'h00, 10'h3FF);
    clr();
    data_wr(8'h55, 10'h3FF, f);
    checks++;
    if (wr_x_q.size() != 10) begin
      errors++; $display("FAIL bcast_count got %0d want 10", wr_x_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++; if (wr_x_q[k] !== exp_x[k]) begin errors++; $display("FAIL bcast_x%0d got %0d want %0d", k, wr_x_q[k], exp_x[k]); end
        checks++; if (wr_y_q[k] !== exp_y[k]) begin errors++; $display("FAIL bcast_y%0d got %0d want %0d", k, wr_y_q[k], exp_y[k]); end
        checks++; if (wr_d_q[k] !== 8'h55) begin errors++; $display("FAIL bcast_d%0d got %0h want 55", k, wr_d_q[k]); end
        checks++; if (wr_cyc_q[k] != f + 5 + k) begin errors++; $display("FAIL bcast_cyc%0d got %0d want %0d", k, wr_cyc_q[k], f + 5 + k); end
      end
    end
  endtask

  task automatic test_clip();
    int f;
    instr(8'h2D, 10'h010);
    clr();
    data_wr(8'h01, 10'h010, f);
    checks++; if (wr_x_q.size() != 0) begin errors++; $display("FAIL clip_first got %0d writes want 0", wr_x_q.size()); end
    instr(8'h3A, 10'h010);
    for (int k = 0; k < 7; k++) data_wr(8'h02, 10'h010, f);
    checks++; if (wr_x_q.size() != 0) begin errors++; $display("FAIL clip_down got %0d writes want 0", wr_x_q.size()); end
    data_wr(8'h03, 10'h010, f);
    checks++;
    if (wr_x_q.size() != 1) begin
      errors++; $display("FAIL clip_edge_count got %0d want 1", wr_x_q.size());
    end else begin
      checks++; if (wr_x_q[0] !== 8'd239) begin errors++; $display("FAIL clip_edge_x got %0d want 239", wr_x_q[0]); end
    end
    instr(8'h3B, 10'h010);
  endtask

  task automatic test_ignored();
    int f;
    instr(8'h00, 10'h001);
    clr();
    bus_cycle(1'b1, 8'h66, 10'h001, 1'b0, 1'b0, f); settle(16);
    bus_cycle(1'b1, 8'h66, 10'h001, 1'b1, 1'b1, f); settle(16);
    bus_cycle(1'b1, 8'h66, 10'h000, 1'b1, 1'b0, f); settle(16);
    checks++; if (wr_x_q.size() != 0) begin errors++; $display("FAIL ignored_count got %0d want 0", wr_x_q.size()); end
    data_wr(8'h99, 10'h001, f);
    data_wr(8'h9A, 10'h001, f);
    checks++;
    if (wr_x_q.size() != 2) begin
      errors++; $display("FAIL ignored_follow_count got %0d want 2", wr_x_q.size());
    end else begin
      checks++; if (wr_x_q[0] !== 8'd0) begin errors++; $display("FAIL ignored_col got %0d want 0", wr_x_q[0]); end
      checks++; if (wr_x_q[1] !== 8'd1) begin errors++; $display("FAIL ignored_next got %0d want 1", wr_x_q[1]); end
      checks++; if (wr_d_q[0] !== 8'h99) begin errors++; $display("FAIL ignored_data got %0h want 99", wr_d_q[0]); end
    end
  endtask

  task automatic test_overrun();
    int f;
    instr(8'h00, 10'h3FF);
    instr(8'h39, 10'h3FF);
    checks++; if (display_on !== 10'h3FF) begin errors++; $display("FAIL ovr_display got %0h want 3ff", display_on); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre got %0h want 0", overrun); end
    clr();
    @(negedge clk);
    data_pin = 8'h77; di_pin = 1'b1; cs_pin = 10'h3FF; cs1_pin = 1'b1; rw_pin = 1'b0; enable_pin = 1'b1;
    repeat (2) @(negedge clk);
    enable_pin = 1'b0;
    @(negedge clk); enable_pin = 1'b1;
    @(negedge clk); data_pin = 8'h88;
    @(negedge clk); enable_pin = 1'b0;
    repeat (2) @(negedge clk);
    enable_pin = 1'b1;
    settle(20);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %0h want 1", overrun); end
    checks++;
    if (wr_x_q.size() != 10) begin
      errors++; $display("FAIL ovr_count got %0d want 10", wr_x_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++; if (wr_d_q[k] !== 8'h77) begin errors++; $display("FAIL ovr_d%0d got %0h want 77", k, wr_d_q[k]); end
      end
    end
    reset_pin = 1'b0;
    settle(4);
    checks++; if (display_on !== 10'h000) begin errors++; $display("FAIL lcdrst_display got %0h want 0", display_on); end
    clr();
    data_wr(8'h44, 10'h001, f);
    checks++; if (wr_x_q.size() != 0) begin errors++; $display("FAIL lcdrst_ignored got %0d writes want 0", wr_x_q.size()); end
    reset_pin = 1'b1;
    settle(4);
    data_wr(8'h12, 10'h020, f);
    checks++;
    if (wr_x_q.size() != 1) begin
      errors++; $display("FAIL lcdrst_after_count got %0d want 1", wr_x_q.size());
    end else begin
      checks++; if (wr_x_q[0] !== 8'd0) begin errors++; $display("FAIL lcdrst_col got %0d want 0", wr_x_q[0]); end
      checks++; if (wr_y_q[0] !== 3'd4) begin errors++; $display("FAIL lcdrst_page got %0d want 4", wr_y_q[0]); end
    end
  endtask

  task automatic test_reset_mid_scan();
    int f, t, n;
    clr();
    bus_cycle(1'b1, 8'hC3, 10'h3FF, 1'b1, 1'b0, f);
    t = 0;
    while (wr_x_q.size() == 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (wr_x_q.size() == 0) begin
      errors++; $display("FAIL midscan_timeout got 0 writes want at least 1");
    end else begin
      reset = 1'b1;
      @(posedge clk);
      #1;
      n = wr_x_q.size();
      settle(6);
      checks++; if (fb_write !== 1'b0) begin errors++; $display("FAIL midscan_fb_write got %0h want 0", fb_write); end
      checks++; if (wr_x_q.size() != n) begin errors++; $display("FAIL midscan_stop got %0d writes want %0d", wr_x_q.size(), n); end
      checks++; if (n >= 10) begin errors++; $display("FAIL midscan_abort got %0d writes want fewer than 10", n); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midscan_overrun got %0h want 0", overrun); end
      reset = 1'b0;
      settle(4);
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_addr_write();
    test_wrap();
    test_broadcast();
    test_clip();
    test_ignored();
    test_overrun();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
